// File: rtl/scaler_coe_pkg.sv
// Shared constants for the horizontal bicubic scaler coefficient ROM.
// Holds the phase count, the phase index width, the 32x4 tap tables for both kernels at
// 10-bit coefficient width, and an elaboration-time helper that regenerates a table row
// for any other coefficient width using integer arithmetic only.
// Row layout: c0 far-lead neg magnitude, c1 near-lead, c2 near-lag, c3 far-lag neg magnitude.
package scaler_coe_pkg;

  localparam int unsigned SCALER_PHASES   = 32;
  localparam int unsigned SCALER_PHASE_W  = 5;
  localparam int unsigned COE_TABLE_WIDTH = 10;

  typedef struct packed {
    logic [COE_TABLE_WIDTH-1:0] c0;
    logic [COE_TABLE_WIDTH-1:0] c1;
    logic [COE_TABLE_WIDTH-1:0] c2;
    logic [COE_TABLE_WIDTH-1:0] c3;
  } coe_row_t;

  // Rows 17..31 are stored as exact mirrors of rows 15..1. Independent rounding of c1 would
  // otherwise break left/right symmetry at a few phases (e.g. 3/29 and 5/27) because c2
  // absorbs the rounding error of the other three taps.
  // Catmull-Rom, a = -0.5
  localparam coe_row_t COE_TABLE_CR [SCALER_PHASES] = '{
    '{10'd0,  10'd0,   10'd512, 10'd0},
    '{10'd0,  10'd9,   10'd511, 10'd8},
    '{10'd1,  10'd20,  10'd507, 10'd14},
    '{10'd2,  10'd32,  10'd502, 10'd20},
    '{10'd4,  10'd47,  10'd494, 10'd25},
    '{10'd5,  10'd62,  10'd483, 10'd28},
    '{10'd7,  10'd79,  10'd472, 10'd32},
    '{10'd10, 10'd97,  10'd459, 10'd34},
    '{10'd12, 10'd116, 10'd444, 10'd36},
    '{10'd15, 10'd136, 10'd428, 10'd37},
    '{10'd17, 10'd157, 10'd410, 10'd38},
    '{10'd20, 10'd178, 10'd392, 10'd38},
    '{10'd23, 10'd200, 10'd373, 10'd38},
    '{10'd25, 10'd222, 10'd352, 10'd37},
    '{10'd28, 10'd244, 10'd331, 10'd35},
    '{10'd30, 10'd266, 10'd310, 10'd34},
    '{10'd32, 10'd288, 10'd288, 10'd32},
    '{10'd34, 10'd310, 10'd266, 10'd30},
    '{10'd35, 10'd331, 10'd244, 10'd28},
    '{10'd37, 10'd352, 10'd222, 10'd25},
    '{10'd38, 10'd373, 10'd200, 10'd23},
    '{10'd38, 10'd392, 10'd178, 10'd20},
    '{10'd38, 10'd410, 10'd157, 10'd17},
    '{10'd37, 10'd428, 10'd136, 10'd15},
    '{10'd36, 10'd444, 10'd116, 10'd12},
    '{10'd34, 10'd459, 10'd97,  10'd10},
    '{10'd32, 10'd472, 10'd79,  10'd7},
    '{10'd28, 10'd483, 10'd62,  10'd5},
    '{10'd25, 10'd494, 10'd47,  10'd4},
    '{10'd20, 10'd502, 10'd32,  10'd2},
    '{10'd14, 10'd507, 10'd20,  10'd1},
    '{10'd8,  10'd511, 10'd9,   10'd0}
  };

  // Sharpened cubic, a = -0.75
  localparam coe_row_t COE_TABLE_SHARP [SCALER_PHASES] = '{
    '{10'd0,  10'd0,   10'd512, 10'd0},
    '{10'd0,  10'd13,  10'd510, 10'd11},
    '{10'd1,  10'd27,  10'd507, 10'd21},
    '{10'd3,  10'd42,  10'd503, 10'd30},
    '{10'd5,  10'd59,  10'd495, 10'd37},
    '{10'd8,  10'd76,  10'd487, 10'd43},
    '{10'd11, 10'd95,  10'd476, 10'd48},
    '{10'd14, 10'd114, 10'd463, 10'd51},
    '{10'd18, 10'd134, 10'd450, 10'd54},
    '{10'd22, 10'd155, 10'd435, 10'd56},
    '{10'd26, 10'd175, 10'd420, 10'd57},
    '{10'd30, 10'd197, 10'd402, 10'd57},
    '{10'd34, 10'd218, 10'd384, 10'd56},
    '{10'd38, 10'd240, 10'd365, 10'd55},
    '{10'd41, 10'd261, 10'd345, 10'd53},
    '{10'd45, 10'd283, 10'd325, 10'd51},
    '{10'd48, 10'd304, 10'd304, 10'd48},
    '{10'd51, 10'd325, 10'd283, 10'd45},
    '{10'd53, 10'd345, 10'd261, 10'd41},
    '{10'd55, 10'd365, 10'd240, 10'd38},
    '{10'd56, 10'd384, 10'd218, 10'd34},
    '{10'd57, 10'd402, 10'd197, 10'd30},
    '{10'd57, 10'd420, 10'd175, 10'd26},
    '{10'd56, 10'd435, 10'd155, 10'd22},
    '{10'd54, 10'd450, 10'd134, 10'd18},
    '{10'd51, 10'd463, 10'd114, 10'd14},
    '{10'd48, 10'd476, 10'd95,  10'd11},
    '{10'd43, 10'd487, 10'd76,  10'd8},
    '{10'd37, 10'd495, 10'd59,  10'd5},
    '{10'd30, 10'd503, 10'd42,  10'd3},
    '{10'd21, 10'd507, 10'd27,  10'd1},
    '{10'd11, 10'd510, 10'd13,  10'd0}
  };

  // Elaboration-time row generator. Returns {c0, c1, c2, c3} in 16-bit fields.
  // With j = phase in 1/32 steps, each tap is an integer polynomial over a power-of-two
  // denominator, so round-half-up is (2*U*num + den) / (2*den) with no real arithmetic.
  function automatic logic [63:0] coe_row(input int unsigned width, input bit sharp,
                                          input int unsigned k);
    logic [4:0] idx;
    coe_row_t   r;
    longint     j, u, den, n0, n1, n3, c0, c1, c2, c3;
    bit         mirror;
    idx = k[4:0];
    if (width == COE_TABLE_WIDTH) begin
      r = sharp ? COE_TABLE_SHARP[idx] : COE_TABLE_CR[idx];
      return {6'd0, r.c0, 6'd0, r.c1, 6'd0, r.c2, 6'd0, r.c3};
    end
    j      = longint'(idx);
    mirror = (j > 16);
    if (mirror) j = 32 - j;
    u = 64'd1 << (width - 1);
    if (sharp) begin
      den = 131072;
      n0  = 3 * j * j * (32 - j);
      n3  = 3 * j * (32 - j) * (32 - j);
      n1  = 3072 * j + 192 * j * j - 5 * j * j * j;
    end else begin
      den = 65536;
      n0  = j * j * (32 - j);
      n3  = j * (32 - j) * (32 - j);
      n1  = 1024 * j + 128 * j * j - 3 * j * j * j;
    end
    c0 = (2 * u * n0 + den) / (2 * den);
    c1 = (2 * u * n1 + den) / (2 * den);
    c3 = (2 * u * n3 + den) / (2 * den);
    // c2 absorbs all rounding so that c1 + c2 - c0 - c3 == U exactly
    c2 = u - c1 + c0 + c3;
    if (mirror) return {c3[15:0], c2[15:0], c1[15:0], c0[15:0]};
    return {c0[15:0], c1[15:0], c2[15:0], c3[15:0]};
  endfunction

endpackage

// File: rtl/scaler_coe_rom_if.sv
// Phase-address / coefficient bus of the scaler coefficient ROM.
//   addr     phase index (t = addr/32), driven by the scaler
//   rom0_do  far-lead negative tap magnitude
//   rom1_do  near-lead positive tap
//   rom2_do  near-lag positive tap
//   rom3_do  far-lag negative tap magnitude
// master: scaler datapath side. slave: ROM side.
interface scaler_coe_rom_if
  import scaler_coe_pkg::*;
#(
  parameter int unsigned COE_WIDTH = 10
);
  logic [SCALER_PHASE_W-1:0] addr;
  logic [COE_WIDTH-1:0]      rom0_do;
  logic [COE_WIDTH-1:0]      rom1_do;
  logic [COE_WIDTH-1:0]      rom2_do;
  logic [COE_WIDTH-1:0]      rom3_do;

  modport master (output addr, input rom0_do, rom1_do, rom2_do, rom3_do);
  modport slave  (input addr, output rom0_do, rom1_do, rom2_do, rom3_do);
endinterface

// File: rtl/scaler_coe_rom.sv
// Synchronous bicubic coefficient ROM: one constant lookup followed by an output register.
// Latency is one clock; outputs update every cycle.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset, clears all four outputs
//   bus  scaler_coe_rom_if.slave (addr in, rom0_do..rom3_do out)
// Parameter COE_WIDTH (10..16): coefficient width, unity gain 2^(COE_WIDTH-1).
// Build option: define SCALER_COE_ROM_SHARP_EN to use the a = -0.75 kernel instead of
// Catmull-Rom (a = -0.5). Ports and latency are the same in both builds.
module scaler_coe_rom
  import scaler_coe_pkg::*;
#(
  parameter int unsigned COE_WIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  scaler_coe_rom_if.slave   bus
);

`ifdef SCALER_COE_ROM_SHARP_EN
  localparam bit SharpEn = 1'b1;
`else
  localparam bit SharpEn = 1'b0;
`endif

  typedef struct packed {
    logic [COE_WIDTH-1:0] c0;
    logic [COE_WIDTH-1:0] c1;
    logic [COE_WIDTH-1:0] c2;
    logic [COE_WIDTH-1:0] c3;
  } row_t;

  row_t rom_tbl [SCALER_PHASES];
  row_t row_d;
  row_t row_q;

  // Table rows are elaboration-time constants; this reduces to a constant mux.
  for (genvar k = 0; k < SCALER_PHASES; k++) begin : g_tbl
    localparam logic [63:0] RowBits = coe_row(COE_WIDTH, SharpEn, k);
    assign rom_tbl[k] = '{
      c0: RowBits[48 +: COE_WIDTH],
      c1: RowBits[32 +: COE_WIDTH],
      c2: RowBits[16 +: COE_WIDTH],
      c3: RowBits[0  +: COE_WIDTH]
    };
  end

  always_comb begin
    row_d = rom_tbl[bus.addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
    end else begin
      row_q <= row_d;
    end
  end

  assign bus.rom0_do = row_q.c0;
  assign bus.rom1_do = row_q.c1;
  assign bus.rom2_do = row_q.c2;
  assign bus.rom3_do = row_q.c3;

endmodule

// File: tb/tb_scaler_coe_rom.sv
// Self-checking bench for scaler_coe_rom at COE_WIDTH = 10.
// Expected rows come from hand-computed anchors and a small integer kernel model.
// Honours SCALER_COE_ROM_SHARP_EN the same way as the design.
module tb_scaler_coe_rom;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [39:0] obs;
  logic [39:0] got [32];

`ifdef SCALER_COE_ROM_SHARP_EN
  localparam logic [39:0] Row0  = {10'd0,  10'd0,   10'd512, 10'd0};
  localparam logic [39:0] Row8  = {10'd18, 10'd134, 10'd450, 10'd54};
  localparam logic [39:0] Row16 = {10'd48, 10'd304, 10'd304, 10'd48};
  localparam logic [39:0] Row31 = {10'd11, 10'd510, 10'd13,  10'd0};
`else
  localparam logic [39:0] Row0  = {10'd0,  10'd0,   10'd512, 10'd0};
  localparam logic [39:0] Row8  = {10'd12, 10'd116, 10'd444, 10'd36};
  localparam logic [39:0] Row16 = {10'd32, 10'd288, 10'd288, 10'd32};
  localparam logic [39:0] Row31 = {10'd8,  10'd511, 10'd9,   10'd0};
`endif

  scaler_coe_rom_if #(.COE_WIDTH(10)) bus ();

  scaler_coe_rom #(.COE_WIDTH(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.rom0_do, bus.rom1_do, bus.rom2_do, bus.rom3_do};

  // Kernel model: rows 0..16 from the rounded polynomials, upper rows mirrored.
  function automatic logic [39:0] exp_row(input int k);
    int j, den, n0, n1, n3, c0, c1, c2, c3;
    j = (k > 16) ? 32 - k : k;
`ifdef SCALER_COE_ROM_SHARP_EN
    den = 131072;
    n0  = 3 * j * j * (32 - j);
    n3  = 3 * j * (32 - j) * (32 - j);
    n1  = 3072 * j + 192 * j * j - 5 * j * j * j;
`else
    den = 65536;
    n0  = j * j * (32 - j);
    n3  = j * (32 - j) * (32 - j);
    n1  = 1024 * j + 128 * j * j - 3 * j * j * j;
`endif
    c0 = (1024 * n0 + den) / (2 * den);
    c1 = (1024 * n1 + den) / (2 * den);
    c3 = (1024 * n3 + den) / (2 * den);
    c2 = 512 - c1 + c0 + c3;
    if (k > 16) return {c3[9:0], c2[9:0], c1[9:0], c0[9:0]};
    return {c0[9:0], c1[9:0], c2[9:0], c3[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.addr  = 5'd16;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (obs !== 40'd0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got %h want %h", i, obs, 40'd0);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (obs !== Row16) begin
      errors++;
      $display("FAIL reset_release got %h want %h", obs, Row16);
    end
  endtask

  task automatic test_latency();
    bus.addr = 5'd0;
    tick();
    checks++;
    if (obs !== Row0) begin
      errors++;
      $display("FAIL latency_row0 got %h want %h", obs, Row0);
    end
    bus.addr = 5'd8;
    #1;
    checks++;
    if (obs !== Row0) begin
      errors++;
      $display("FAIL latency_no_comb_path got %h want %h", obs, Row0);
    end
    tick();
    checks++;
    if (obs !== Row8) begin
      errors++;
      $display("FAIL latency_row8 got %h want %h", obs, Row8);
    end
    bus.addr = 5'd16;
    tick();
    checks++;
    if (obs !== Row16) begin
      errors++;
      $display("FAIL latency_row16 got %h want %h", obs, Row16);
    end
  endtask

  task automatic test_sweep();
    int dc;
    for (int k = 0; k < 32; k++) begin
      bus.addr = 5'(k);
      tick();
      got[k] = obs;
      checks++;
      if (obs !== exp_row(k)) begin
        errors++;
        $display("FAIL sweep_row addr=%0d got %h want %h", k, obs, exp_row(k));
      end
      dc = int'(obs[29:20]) + int'(obs[19:10]) - int'(obs[39:30]) - int'(obs[9:0]);
      checks++;
      if (dc !== 512) begin
        errors++;
        $display("FAIL sweep_dc addr=%0d got %0d want 512", k, dc);
      end
      checks++;
      if (obs[39:30] > 10'd512 || obs[29:20] > 10'd512 ||
          obs[19:10] > 10'd512 || obs[9:0] > 10'd512) begin
        errors++;
        $display("FAIL sweep_max addr=%0d got %h want all <= 512", k, obs);
      end
    end
    for (int k = 1; k < 16; k++) begin
      checks++;
      if (got[32-k] !== {got[k][9:0], got[k][19:10], got[k][29:20], got[k][39:30]}) begin
        errors++;
        $display("FAIL symmetry k=%0d got %h want mirror of %h", k, got[32-k], got[k]);
      end
    end
  endtask

  task automatic test_hold_wrap();
    bus.addr = 5'd8;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== Row8) begin
        errors++;
        $display("FAIL hold cycle=%0d got %h want %h", i, obs, Row8);
      end
    end
    bus.addr = 5'd31;
    tick();
    checks++;
    if (obs !== Row31) begin
      errors++;
      $display("FAIL wrap_row31 got %h want %h", obs, Row31);
    end
    bus.addr = 5'd0;
    tick();
    checks++;
    if (obs !== Row0) begin
      errors++;
      $display("FAIL wrap_row0 got %h want %h", obs, Row0);
    end
  endtask

  task automatic test_mid_reset();
    logic [39:0] want;
    for (int k = 4; k <= 12; k++) begin
      bus.addr = 5'(k);
      rst      = (k == 8);
      tick();
      want = (k == 8) ? 40'd0 : exp_row(k);
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL mid_reset addr=%0d got %h want %h", k, obs, want);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.addr = 5'd0;
    test_reset();
    test_latency();
    test_sweep();
    test_hold_wrap();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
